// File: rtl/ssio_sdr_in_frame.sv
// Source-synchronous SDR receive framer: pad capture, one-word lookahead,
// burst framing FSM with overlength truncation and link-idle detection.
module ssio_sdr_in_frame #(
    parameter integer WIDTH        = 8,
    parameter integer MAX_LEN      = 2048,
    parameter integer IDLE_TIMEOUT = 255
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire [WIDTH-1:0] input_d,
    input  wire             input_ctl,
    output reg  [WIDTH-1:0] output_d,
    output reg              output_valid,
    output reg              output_first,
    output reg              output_last,
    output reg              output_err,
    output reg  [15:0]      burst_len,
    output reg              burst_len_valid,
    output wire             stat_idle,
    output reg              stat_overlen
);

    localparam [1:0] S_SYNC  = 2'd0;
    localparam [1:0] S_IDLE  = 2'd1;
    localparam [1:0] S_BURST = 2'd2;
    localparam [1:0] S_DROP  = 2'd3;

    localparam [15:0] MAX_W  = MAX_LEN[15:0];
    localparam [15:0] IDLE_W = IDLE_TIMEOUT[15:0];

    (* IOB = "TRUE" *) reg [WIDTH-1:0] iob_d_q;
    (* IOB = "TRUE" *) reg             iob_ctl_q;
    reg             iob_vld_q;
    reg [WIDTH-1:0] la_d_q;
    reg             la_ctl_q;
    reg             la_vld_q;
    reg [1:0]       state_q;
    reg [15:0]      cnt_q;
    reg [15:0]      idle_q;

    wire [15:0] cnt_inc  = cnt_q + 16'd1;
    wire [15:0] idle_inc = (idle_q == IDLE_W) ? idle_q : idle_q + 16'd1;

    // Run length of zeros up to and including the word now in the pad register.
    wire [15:0] idle_d = (!iob_vld_q || iob_ctl_q) ? 16'd0 : idle_inc;

    assign stat_idle = (idle_d == IDLE_W);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iob_d_q   <= {WIDTH{1'b0}};
            iob_ctl_q <= 1'b0;
            iob_vld_q <= 1'b0;
            la_d_q    <= {WIDTH{1'b0}};
            la_ctl_q  <= 1'b0;
            la_vld_q  <= 1'b0;
            idle_q    <= 16'd0;
        end else begin
            iob_d_q   <= input_d;
            iob_ctl_q <= input_ctl;
            iob_vld_q <= 1'b1;
            la_d_q    <= iob_d_q;
            la_ctl_q  <= iob_ctl_q;
            la_vld_q  <= iob_vld_q;
            idle_q    <= idle_d;
        end
    end

    // Framing decisions act on the lookahead word, peeking at the pad word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_SYNC;
            cnt_q           <= 16'd0;
            output_d        <= {WIDTH{1'b0}};
            output_valid    <= 1'b0;
            output_first    <= 1'b0;
            output_last     <= 1'b0;
            output_err      <= 1'b0;
            burst_len       <= 16'd0;
            burst_len_valid <= 1'b0;
            stat_overlen    <= 1'b0;
        end else begin
            output_valid    <= 1'b0;
            output_first    <= 1'b0;
            output_last     <= 1'b0;
            output_err      <= 1'b0;
            burst_len_valid <= 1'b0;
            stat_overlen    <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    if (la_vld_q && !la_ctl_q)
                        state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (la_ctl_q) begin
                        output_d     <= la_d_q;
                        output_valid <= 1'b1;
                        output_first <= 1'b1;
                        cnt_q        <= 16'd1;
                        if (!iob_ctl_q) begin
                            output_last     <= 1'b1;
                            burst_len       <= 16'd1;
                            burst_len_valid <= 1'b1;
                        end else begin
                            state_q <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (!la_ctl_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        output_d     <= la_d_q;
                        output_valid <= 1'b1;
                        cnt_q        <= cnt_inc;
                        if (cnt_inc == MAX_W) begin
                            output_last     <= 1'b1;
                            burst_len       <= cnt_inc;
                            burst_len_valid <= 1'b1;
                            if (iob_ctl_q) begin
                                output_err   <= 1'b1;
                                stat_overlen <= 1'b1;
                                state_q      <= S_DROP;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else if (!iob_ctl_q) begin
                            output_last     <= 1'b1;
                            burst_len       <= cnt_inc;
                            burst_len_valid <= 1'b1;
                            state_q         <= S_IDLE;
                        end
                    end
                end
                default: begin
                    if (!la_ctl_q)
                        state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssio_sdr_in_frame.sv
// Scoreboard bench for ssio_sdr_in_frame: directed bursts, truncation,
// idle detection and reset behaviour with MAX_LEN=8, IDLE_TIMEOUT=5.
module tb_ssio_sdr_in_frame;

    typedef struct packed {
        logic [7:0]  d;
        logic        f;
        logic        l;
        logic        e;
        logic [15:0] len;
        logic [31:0] t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  input_d = 8'h00;
    logic        input_ctl = 1'b0;
    logic [7:0]  output_d;
    logic        output_valid;
    logic        output_first;
    logic        output_last;
    logic        output_err;
    logic [15:0] burst_len;
    logic        burst_len_valid;
    logic        stat_idle;
    logic        stat_overlen;

    ssio_sdr_in_frame #(
        .WIDTH(8),
        .MAX_LEN(8),
        .IDLE_TIMEOUT(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .input_d(input_d),
        .input_ctl(input_ctl),
        .output_d(output_d),
        .output_valid(output_valid),
        .output_first(output_first),
        .output_last(output_last),
        .output_err(output_err),
        .burst_len(burst_len),
        .burst_len_valid(burst_len_valid),
        .stat_idle(stat_idle),
        .stat_overlen(stat_overlen)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ovl_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tx(input logic ctl, input logic [7:0] d,
                      input logic push, input logic f, input logic l,
                      input logic e, input logic [15:0] len);
        @(negedge clk);
        input_ctl = ctl;
        input_d   = d;
        if (push)
            sb.push_back('{d: d, f: f, l: l, e: e, len: len,
                           t: 32'(cyc + 3)});
    endtask

    task automatic gap(input int n);
        repeat (n) tx(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({output_d, output_valid, output_first, output_last,
                    output_err, burst_len, burst_len_valid, stat_idle,
                    stat_overlen});
    endfunction

    // Monitor: every presented word is matched against the scoreboard head.
    always @(negedge clk) begin
        if (stat_overlen) ovl_cnt++;
        if (rst_n) begin
            if (output_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got d=%h first=%b last=%b",
                             output_d, output_first, output_last);
                end else begin
                    mon_e = sb.pop_front();
                    mon_g.d   = output_d;
                    mon_g.f   = output_first;
                    mon_g.l   = output_last;
                    mon_g.e   = output_err;
                    mon_g.len = burst_len_valid ? burst_len : 16'd0;
                    mon_g.t   = 32'(cyc);
                    chk("word", 64'(mon_g), 64'(mon_e));
                    chk("word_strobes", {62'd0, burst_len_valid, stat_overlen},
                        {62'd0, mon_e.l, mon_e.e});
                end
            end else begin
                chk("flags_without_valid",
                    {59'd0, output_first, output_last, output_err,
                     burst_len_valid, stat_overlen}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // 4-word burst after 3 idle cycles
        gap(3);
        tx(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
        gap(4);
        drain("burst4_drain");

        // single word, then idle timeout and clear
        tx(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        for (int k = 1; k <= 10; k++) begin
            tx(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk($sformatf("stat_idle_%0d", k), 64'(stat_idle),
                (k >= 6) ? 64'd1 : 64'd0);
        end
        tx(1'b1, 8'h51, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("stat_idle_before_ctl", 64'(stat_idle), 64'd1);
        tx(1'b1, 8'h52, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
        chk("stat_idle_cleared", 64'(stat_idle), 64'd0);
        gap(4);
        drain("single_idle_drain");

        // 12-word burst truncated at MAX_LEN=8
        ovl_cnt = 0;
        for (int i = 1; i <= 12; i++)
            tx(1'b1, 8'(i), (i <= 8), (i == 1), (i == 8), (i == 8),
               (i == 8) ? 16'd8 : 16'd0);
        gap(4);
        drain("overlen_drain");
        chk("overlen_pulses", 64'(ovl_cnt), 64'd1);

        // exactly MAX_LEN words: last without err
        for (int i = 1; i <= 8; i++)
            tx(1'b1, 8'(8'h20 + i), 1'b1, (i == 1), (i == 8), 1'b0,
               (i == 8) ? 16'd8 : 16'd0);
        gap(4);
        drain("exact_max_drain");
        chk("exact_max_no_overlen", 64'(ovl_cnt), 64'd1);

        // reset released mid-burst: discarded until ctl=0
        @(negedge clk);
        rst_n = 1'b0;
        input_ctl = 1'b1;
        input_d = 8'h61;
        #1 chk("reset_assert_zero", all_outs(), 64'd0);
        tx(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tx(1'b1, 8'h65, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h67, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        gap(3);
        tx(1'b1, 8'h71, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h72, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h73, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3);
        gap(4);
        drain("sync_recovery_drain");

        // reset asserted while word 3 of 6 is on the output
        tx(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h83, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h84, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h85, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h86, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        #1 rst_n = 1'b0;
        #1 chk("midburst_reset_zero", all_outs(), 64'd0);
        chk("midburst_reset_queue", 64'(sb.size()), 64'd0);
        @(negedge clk);
        input_ctl = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap(5);
        tx(1'b1, 8'h91, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        tx(1'b1, 8'h92, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
        gap(4);
        drain("post_reset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
